dmem_responder: RTL and testbench

- Data-memory responder on the core's M-stage data port. It is the far end of MemWriteM/ALUResultM/WriteDataM/ReadDataM.
- Decodes the address into a word RAM region and a memory-mapped peripheral region: GPIO output register and a prescaled 32-bit timer with compare match and interrupt.
- Reads are zero-latency because the core consumes ReadDataM in the same cycle. Writes commit on the rising edge.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_timer.sv | 82 ++++++++
 rtl/dmem_responder.sv | 86 ++++++++
 tb/tb_dmem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data-memory responder: register map, CTRL bits
// and the address-region decode.
package dmem_pkg;

  localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;

  localparam logic [4:0] OffGpio  = 5'h00;
  localparam logic [4:0] OffCount = 5'h04;
  localparam logic [4:0] OffCmp   = 5'h08;
  localparam logic [4:0] OffCtrl  = 5'h0C;
  localparam logic [4:0] OffPresc = 5'h10;

  localparam int unsigned CtrlEn      = 0;
  localparam int unsigned CtrlMatch   = 1;
  localparam int unsigned CtrlAutoClr = 2;
  localparam int unsigned CtrlIrqEn   = 3;

  typedef enum logic [1:0] {RegionRam, RegionPeriph, RegionNone} region_e;

endpackage

// File: rtl/dmem_timer.sv
// Prescaled 32-bit timer with compare match, auto-clear and level interrupt.
// Register writes arrive already decoded to a word offset inside the peripheral block.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d, cmp_q, cmp_d;
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic        en_q, en_d, match_q, match_d, auto_clr_q, auto_clr_d, irq_en_q, irq_en_d;
  logic        wr_count, wr_cmp, wr_ctrl, wr_presc, tick, hit;

  always_comb begin
    wr_count = we_i && (off_i == OffCount);
    wr_cmp   = we_i && (off_i == OffCmp);
    wr_ctrl  = we_i && (off_i == OffCtrl);
    wr_presc = we_i && (off_i == OffPresc);
    tick     = en_q && (pcnt_q == presc_q);
    hit      = tick && (count_q == cmp_q);

    // A CPU write to COUNT overrides both the increment and the auto-clear.
    count_d = count_q;
    if (wr_count) begin
      count_d = wdata_i;
    end else if (tick) begin
      count_d = (hit && auto_clr_q) ? 32'd0 : count_q + 32'd1;
    end

    pcnt_d  = (wr_presc || !en_q || tick) ? 16'd0 : pcnt_q + 16'd1;
    cmp_d   = wr_cmp ? wdata_i : cmp_q;
    presc_d = wr_presc ? wdata_i[15:0] : presc_q;

    en_d       = wr_ctrl ? wdata_i[CtrlEn] : en_q;
    auto_clr_d = wr_ctrl ? wdata_i[CtrlAutoClr] : auto_clr_q;
    irq_en_d   = wr_ctrl ? wdata_i[CtrlIrqEn] : irq_en_q;
    // New match wins over a same-cycle write-1-to-clear.
    match_d    = hit || (match_q && !(wr_ctrl && wdata_i[CtrlMatch]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      cmp_q      <= '0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      en_q       <= 1'b0;
      match_q    <= 1'b0;
      auto_clr_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      en_q       <= en_d;
      match_q    <= match_d;
      auto_clr_q <= auto_clr_d;
      irq_en_q   <= irq_en_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      OffCount: rdata_o = count_q;
      OffCmp:   rdata_o = cmp_q;
      OffCtrl:  rdata_o = {28'd0, irq_en_q, auto_clr_q, match_q, en_q};
      OffPresc: rdata_o = {16'd0, presc_q};
      default:  rdata_o = '0;
    endcase
  end

  assign irq_o = match_q && irq_en_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's M stage: word RAM, GPIO register and timer block.
// Reads are combinational from the address; writes commit on the rising edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  parameter int unsigned GPIO_W      = 8,
  parameter logic [31:0] ERR_DATA    = ErrDataDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic [GPIO_W-1:0] GpioOut,
  output logic              TimerIrq,
  output logic              BusErr
);

  localparam int unsigned IdxW = $clog2(RAM_WORDS);

  logic [31:0]       mem_q [RAM_WORDS];
  logic [31:0]       periph_off, timer_rdata;
  logic [IdxW-1:0]   ram_idx;
  logic [GPIO_W-1:0] gpio_q;
  logic              bus_err_q, timer_we, gpio_sel;
  region_e           region;

  always_comb begin
    periph_off = ALUResultM - PERIPH_BASE;
    ram_idx    = ALUResultM[IdxW+1:2];
    gpio_sel   = (periph_off[4:0] == OffGpio);
    if (ALUResultM[1:0] != 2'b00) begin
      region = RegionNone;
    end else if (ALUResultM[31:IdxW+2] == '0) begin
      region = RegionRam;
    end else if (periph_off <= 32'h10) begin
      region = RegionPeriph;
    end else begin
      region = RegionNone;
    end

    case (region)
      RegionRam:    ReadDataM = mem_q[ram_idx];
      RegionPeriph: ReadDataM = gpio_sel ? 32'(gpio_q) : timer_rdata;
      default:      ReadDataM = ERR_DATA;
    endcase

    timer_we = MemWriteM && (region == RegionPeriph) && !gpio_sel;
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (MemWriteM && (region == RegionRam)) begin
      mem_q[ram_idx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (MemWriteM && (region == RegionPeriph) && gpio_sel) begin
        gpio_q <= WriteDataM[GPIO_W-1:0];
      end
      bus_err_q <= MemWriteM && (region == RegionNone);
    end
  end

  dmem_timer u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (timer_we),
    .off_i   (periph_off[4:0]),
    .wdata_i (WriteDataM),
    .rdata_o (timer_rdata),
    .irq_o   (TimerIrq)
  );

  assign GpioOut = gpio_q;
  assign BusErr  = bus_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a register-map level reference model.
module tb_dmem_responder;

  localparam logic [31:0] PB  = 32'h8000_0000;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic [7:0]  GpioOut;
  logic        TimerIrq, BusErr;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] ram_m [256];
  bit          ram_k [256];
  logic [7:0]  gpio_m;
  logic [31:0] count_m, cmp_m;
  logic [15:0] presc_m;
  int          phase_m;
  bit          en_m, match_m, auto_m, irqen_m, buserr_m;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .GpioOut    (GpioOut),
    .TimerIrq   (TimerIrq),
    .BusErr     (BusErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - PB;
    if (a[1:0] != 2'b00) return ERR;
    if (a < 32'd1024) return ram_m[a[9:2]];
    case (off)
      32'h00:  return {24'd0, gpio_m};
      32'h04:  return count_m;
      32'h08:  return cmp_m;
      32'h0C:  return {28'd0, irqen_m, auto_m, match_m, en_m};
      32'h10:  return {16'd0, presc_m};
      default: return ERR;
    endcase
  endfunction

  function automatic bit m_irq();
    return match_m && irqen_m;
  endfunction

  function automatic bit ram_unknown(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return (a[1:0] == 2'b00) && (a < 32'd1024) && !ram_k[idx];
  endfunction

  task automatic m_reset();
    gpio_m = '0; count_m = '0; cmp_m = '0; presc_m = '0; phase_m = 0;
    en_m = 0; match_m = 0; auto_m = 0; irqen_m = 0; buserr_m = 0;
  endtask

  // One clock edge of the register map: the timer ticks on every (PRESC+1)-th enabled
  // cycle, then any CPU write applies on top.
  task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [7:0]  idx;
    bit tick, hit;
    off  = a - PB;
    idx  = a[9:2];
    tick = en_m && (phase_m == int'(presc_m));
    hit  = tick && (count_m == cmp_m);
    phase_m = (!en_m || tick) ? 0 : phase_m + 1;
    if (tick) count_m = (hit && auto_m) ? 32'd0 : count_m + 32'd1;
    buserr_m = 0;
    if (we) begin
      if (a[1:0] != 2'b00) buserr_m = 1;
      else if (a < 32'd1024) begin
        ram_m[idx] = d;
        ram_k[idx] = 1;
      end else begin
        case (off)
          32'h00: gpio_m = d[7:0];
          32'h04: count_m = d;
          32'h08: cmp_m = d;
          32'h0C: begin
            en_m = d[0]; auto_m = d[2]; irqen_m = d[3];
            if (d[1]) match_m = 0;
          end
          32'h10: begin presc_m = d[15:0]; phase_m = 0; end
          default: buserr_m = 1;
        endcase
      end
    end
    if (hit) match_m = 1;
  endtask

  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
    MemWriteM = we; ALUResultM = a; WriteDataM = d;
    @(posedge clk);
    m_edge(we, a, d);
    #1;
    MemWriteM = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a);
    MemWriteM = 1'b0; ALUResultM = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_reset();
    #12;
    total++; if (GpioOut !== 8'h00) begin bad++; $display("FAIL reset_gpio: got %h want 00", GpioOut); end
    total++; if (TimerIrq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", TimerIrq); end
    total++; if (BusErr !== 1'b0) begin bad++; $display("FAIL reset_buserr: got %b want 0", BusErr); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    peek(PB + 32'h4);
    total++; if (ReadDataM !== 32'h0) begin bad++; $display("FAIL reset_count: got %h want 0", ReadDataM); end
    peek(PB + 32'hC);
    total++; if (ReadDataM !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", ReadDataM); end
  endtask

  task automatic test_ram();
    logic [31:0] q[$];
    logic [31:0] a;
    step(1, 32'h10, 32'hCAFE_0000);
    MemWriteM = 1'b1; ALUResultM = 32'h10; WriteDataM = 32'h1234_5678;
    #1;
    total++; if (ReadDataM !== 32'hCAFE_0000) begin bad++; $display("FAIL ram_old_in_write: got %h want cafe0000", ReadDataM); end
    @(posedge clk);
    m_edge(1, 32'h10, 32'h1234_5678);
    #1;
    peek(32'h10);
    total++; if (ReadDataM !== 32'h1234_5678) begin bad++; $display("FAIL ram_readback: got %h want 12345678", ReadDataM); end
    q.push_back(32'h0); q.push_back(32'h3FC);
    for (int i = 0; i < 14; i++) q.push_back(32'($urandom_range(0, 255)) << 2);
    foreach (q[i]) step(1, q[i], $urandom);
    foreach (q[i]) begin
      a = q[i];
      peek(a);
      total++; if (ReadDataM !== m_read(a)) begin bad++; $display("FAIL ram_rand @%h: got %h want %h", a, ReadDataM, m_read(a)); end
    end
  endtask

  task automatic test_gpio();
    step(1, PB, 32'h0000_00A5);
    total++; if (GpioOut !== 8'hA5) begin bad++; $display("FAIL gpio_out: got %h want a5", GpioOut); end
    peek(PB);
    total++; if (ReadDataM !== 32'h0000_00A5) begin bad++; $display("FAIL gpio_read: got %h want 000000a5", ReadDataM); end
    for (int i = 0; i < 4; i++) begin
      step(1, PB, $urandom);
      peek(PB);
      total++; if (GpioOut !== gpio_m || ReadDataM !== m_read(PB)) begin
        bad++; $display("FAIL gpio_rand: got out=%h rd=%h want out=%h rd=%h", GpioOut, ReadDataM, gpio_m, m_read(PB));
      end
    end
  endtask

  task automatic test_timer_match();
    bit seen;
    seen = 0;
    step(1, PB + 32'h8, 32'd3);
    step(1, PB + 32'h10, 32'd1);
    step(1, PB + 32'h4, 32'd0);
    step(1, PB + 32'hC, 32'b1001);
    for (int i = 0; i < 14; i++) begin
      peek(PB + 32'h4);
      total++; if (ReadDataM !== m_read(PB + 32'h4)) begin bad++; $display("FAIL timer_count[%0d]: got %h want %h", i, ReadDataM, m_read(PB + 32'h4)); end
      if (TimerIrq === 1'b1 && !seen) begin
        seen = 1;
        total++; if (ReadDataM !== 32'd4) begin bad++; $display("FAIL timer_irq_at: count %h want 4", ReadDataM); end
      end
      step(0, PB + 32'h4, 32'd0);
      total++; if (TimerIrq !== m_irq()) begin bad++; $display("FAIL timer_irq[%0d]: got %b want %b", i, TimerIrq, m_irq()); end
    end
    total++; if (TimerIrq !== 1'b1) begin bad++; $display("FAIL timer_irq_set: got %b want 1", TimerIrq); end
    step(1, PB + 32'hC, 32'b1011);
    total++; if (TimerIrq !== 1'b0) begin bad++; $display("FAIL timer_w1c: got %b want 0", TimerIrq); end
  endtask

  task automatic test_auto_clr();
    logic [31:0] exp_seq [6];
    exp_seq = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
    step(1, PB + 32'hC, 32'b0010);
    step(1, PB + 32'h4, 32'd0);
    step(1, PB + 32'h8, 32'd2);
    step(1, PB + 32'h10, 32'd0);
    step(1, PB + 32'hC, 32'b0101);
    for (int i = 0; i < 6; i++) begin
      peek(PB + 32'h4);
      total++; if (ReadDataM !== exp_seq[i] || ReadDataM !== m_read(PB + 32'h4)) begin
        bad++; $display("FAIL autoclr_seq[%0d]: got %h want %h", i, ReadDataM, exp_seq[i]);
      end
      step(0, PB + 32'h4, 32'd0);
    end
    peek(PB + 32'hC);
    total++; if (ReadDataM[1] !== 1'b1) begin bad++; $display("FAIL autoclr_match_sticky: got %b want 1", ReadDataM[1]); end
    step(1, PB + 32'hC, 32'b0010);
    peek(PB + 32'hC);
    total++; if (ReadDataM !== 32'h0 || ReadDataM !== m_read(PB + 32'hC)) begin
      bad++; $display("FAIL autoclr_w1c: got %h want 0", ReadDataM);
    end
  endtask

  task automatic test_wrap();
    step(1, PB + 32'h8, 32'd5);
    step(1, PB + 32'h10, 32'd0);
    step(1, PB + 32'h4, 32'hFFFF_FFFE);
    step(1, PB + 32'hC, 32'd1);
    step(0, PB + 32'h4, 32'd0);
    step(0, PB + 32'h4, 32'd0);
    peek(PB + 32'h4);
    total++; if (ReadDataM !== 32'd0) begin bad++; $display("FAIL count_wrap: got %h want 0", ReadDataM); end
    step(1, PB + 32'h4, 32'h100);
    peek(PB + 32'h4);
    total++; if (ReadDataM !== 32'h100) begin bad++; $display("FAIL write_beats_tick: got %h want 100", ReadDataM); end
    step(1, PB + 32'hC, 32'd0);
  endtask

  task automatic test_bus_err();
    logic [31:0] addrs [6];
    addrs = '{32'h2, PB + 32'h40, PB + 32'h14, 32'h400, PB + 32'h2, PB - 32'h4};
    step(1, 32'h0, 32'h1111_1111);
    foreach (addrs[i]) begin
      peek(addrs[i]);
      total++; if (ReadDataM !== ERR) begin bad++; $display("FAIL buserr_read @%h: got %h want deadbeef", addrs[i], ReadDataM); end
      step(1, addrs[i], $urandom);
      total++; if (BusErr !== 1'b1) begin bad++; $display("FAIL buserr_pulse @%h: got %b want 1", addrs[i], BusErr); end
      step(0, 32'h0, 32'h0);
      total++; if (BusErr !== 1'b0) begin bad++; $display("FAIL buserr_len @%h: got %b want 0", addrs[i], BusErr); end
      peek(32'h0);
      total++; if (ReadDataM !== 32'h1111_1111 || GpioOut !== gpio_m) begin
        bad++; $display("FAIL buserr_nowrite @%h: got mem=%h gpio=%h want 11111111 %h", addrs[i], ReadDataM, GpioOut, gpio_m);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit we;
    int kind;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      if (kind < 4) a = 32'($urandom_range(0, 255)) << 2;
      else if (kind < 8) begin
        a = PB + (32'($urandom_range(0, 4)) << 2);
        if (a != PB + 32'hC) d = d & 32'h7;
      end else if (kind == 8) a = PB + (32'($urandom_range(5, 31)) << 2);
      else a = {$urandom} | 32'h1;
      MemWriteM = we; ALUResultM = a; WriteDataM = d;
      #1;
      if (!ram_unknown(a)) begin
        total++; if (ReadDataM !== m_read(a)) begin bad++; $display("FAIL rand_read[%0d] @%h: got %h want %h", i, a, ReadDataM, m_read(a)); end
      end
      @(posedge clk);
      m_edge(we, a, d);
      #1;
      total++; if (GpioOut !== gpio_m || TimerIrq !== m_irq() || BusErr !== buserr_m) begin
        bad++; $display("FAIL rand_out[%0d]: got gpio=%h irq=%b berr=%b want %h %b %b",
                        i, GpioOut, TimerIrq, BusErr, gpio_m, m_irq(), buserr_m);
      end
    end
    MemWriteM = 1'b0;
  endtask

  task automatic test_reset_mid();
    step(1, PB, 32'hFF);
    step(1, PB + 32'h8, 32'd7);
    step(1, PB + 32'h10, 32'd0);
    step(1, PB + 32'h4, 32'd7);
    step(1, PB + 32'hC, 32'b1001);
    step(0, PB + 32'h4, 32'd0);
    total++; if (TimerIrq !== 1'b1) begin bad++; $display("FAIL rstmid_pre_irq: got %b want 1", TimerIrq); end
    step(1, 32'h2, 32'd0);
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    total++; if (GpioOut !== 8'h0 || TimerIrq !== 1'b0 || BusErr !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got gpio=%h irq=%b berr=%b want 0 0 0", GpioOut, TimerIrq, BusErr);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, PB + 32'h4, 32'd0);
      total++; if (ReadDataM !== 32'd0) begin bad++; $display("FAIL rstmid_frozen[%0d]: got %h want 0", i, ReadDataM); end
    end
    step(1, PB + 32'hC, 32'd1);
    step(0, PB + 32'h4, 32'd0);
    step(0, PB + 32'h4, 32'd0);
    peek(PB + 32'h4);
    total++; if (ReadDataM !== m_read(PB + 32'h4)) begin bad++; $display("FAIL rstmid_restart: got %h want %h", ReadDataM, m_read(PB + 32'h4)); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_k[i] = 0;
    test_reset();
    test_ram();
    test_gpio();
    test_timer_match();
    test_auto_clr();
    test_wrap();
    test_bus_err();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
